// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box table, round constants, schedule length and the
// key-expansion FSM state type.
package aes_pkg;

    typedef enum logic [1:0] {StIdle, StExpand, StDone} key_exp_state_e;

    // Entry b sits at SBOX[2047-8*b -: 8] (byte 0x00 in the MSBs).
    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int unsigned nw(input int unsigned nr);
        return 4 * (nr + 1);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word (purely combinational).
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] data,
    output logic [31:0] result
);

    for (genvar gb = 0; gb < 4; gb++) begin : g_byte
        assign result[8*gb +: 8] = sbox(data[8*gb +: 8]);
    end

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES key expansion, one schedule word per clock into a register file.
// Build option AES_KEYEXP_CLEAR_EN: zero words Nk..Nw-1 when a new key is accepted.
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [32*Nk-1:0]        key,
    output logic                    busy,
    output logic                    done,
    output logic                    w_valid,
    output logic [128*(Nr+1)-1:0]   w
);

    localparam int unsigned Nw     = nw(Nr);
    localparam logic [5:0]  NkIdx  = 6'(Nk);
    localparam logic [5:0]  LastIdx = 6'(Nw - 1);
    localparam logic [2:0]  NkLast = 3'(Nk - 1);

    key_exp_state_e state_q, state_d;
    logic [5:0]     idx_q;
    logic [2:0]     mod_q;
    logic [3:0]     rnd_q;
    logic           w_valid_q;
    logic [31:0]    words_q [Nw];

    logic           accept;
    logic           last_word;
    logic [31:0]    temp;
    logic [31:0]    prev;
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;
    logic [31:0]    word_new;

    assign accept    = (state_q == StIdle) && start;
    assign last_word = (idx_q == LastIdx);
    assign busy      = (state_q == StExpand);
    assign done      = (state_q == StDone);
    assign w_valid   = w_valid_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StExpand;
            StExpand: if (last_word) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    aes_sub_word u_sub_word (
        .data   (sub_in),
        .result (sub_out)
    );

    // mod_q tracks i%Nk and rnd_q tracks i/Nk, so no divider is needed.
    always_comb begin
        temp     = words_q[idx_q - 6'd1];
        prev     = words_q[idx_q - NkIdx];
        sub_in   = (mod_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
        word_new = prev ^ temp;
        if (mod_q == 3'd0) begin
            word_new = prev ^ sub_out ^ {RCON[rnd_q], 24'h0};
        end else if (Nk > 6 && mod_q == 3'd4) begin
            word_new = prev ^ sub_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            mod_q     <= '0;
            rnd_q     <= '0;
            w_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q     <= NkIdx;
                mod_q     <= '0;
                rnd_q     <= 4'd1;
                w_valid_q <= 1'b0;
            end else if (state_q == StExpand) begin
                idx_q <= idx_q + 6'd1;
                if (mod_q == NkLast) begin
                    mod_q <= '0;
                    rnd_q <= rnd_q + 4'd1;
                end else begin
                    mod_q <= mod_q + 3'd1;
                end
                if (last_word) w_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < Nw; j++) words_q[j] <= '0;
        end else if (accept) begin
            for (int j = 0; j < Nk; j++) words_q[j] <= key[32*(Nk-j)-1 -: 32];
`ifdef AES_KEYEXP_CLEAR_EN
            for (int j = Nk; j < Nw; j++) words_q[j] <= '0;
`endif
        end else if (state_q == StExpand) begin
            words_q[idx_q] <= word_new;
        end
    end

    for (genvar gi = 0; gi < Nw; gi++) begin : g_w
        assign w[128*(gi/4) + 96 - 32*(gi%4) +: 32] = words_q[gi];
    end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion: AES-128/192/256 instances, FIPS-197 vectors.
module tb_aes_key_expansion;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    logic s128 = 1'b0, s192 = 1'b0, s256 = 1'b0;
    logic [127:0] k128 = '0;
    logic [191:0] k192 = '0;
    logic [255:0] k256 = '0;
    logic b128, d128, v128, b192, d192, v192, b256, d256, v256;
    logic [1407:0] w128;
    logic [1663:0] w192;
    logic [1919:0] w256;

    aes_key_expansion #(.Nk(4), .Nr(10)) dut128 (
        .clk(clk), .rst_n(rst_n), .start(s128), .key(k128),
        .busy(b128), .done(d128), .w_valid(v128), .w(w128)
    );
    aes_key_expansion #(.Nk(6), .Nr(12)) dut192 (
        .clk(clk), .rst_n(rst_n), .start(s192), .key(k192),
        .busy(b192), .done(d192), .w_valid(v192), .w(w192)
    );
    aes_key_expansion #(.Nk(8), .Nr(14)) dut256 (
        .clk(clk), .rst_n(rst_n), .start(s256), .key(k256),
        .busy(b256), .done(d256), .w_valid(v256), .w(w256)
    );

    typedef struct packed {
        logic [1919:0]    sched;
        logic [4:0][5:0]  idx;
        logic [4:0][31:0] val;
        logic [31:0]      due;
    } exp_t;

    exp_t q128[$], q192[$], q256[$];
    logic [7:0] ref_sb [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Reference S-box from GF(2^8) inverse plus affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] a);
        logic [7:0] inv = '0;
        for (int b = 1; b < 256; b++) if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {ref_sb[x[31:24]], ref_sb[x[23:16]], ref_sb[x[15:8]], ref_sb[x[7:0]]};
    endfunction

    function automatic logic [31:0] wd(input logic [1919:0] v, input int i);
        return v[128*(i/4) + 96 - 32*(i%4) +: 32];
    endfunction

    function automatic logic [1919:0] model(input logic [255:0] k, input int nk);
        logic [31:0]   ws [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] r = '0;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                ws[i] = k[32*(nk-i)-1 -: 32];
            end else begin
                t = ws[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                ws[i] = ws[i-nk] ^ t;
            end
            r[128*(i/4) + 96 - 32*(i%4) +: 32] = ws[i];
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [1919:0] s, input int due,
                                input logic [4:0][5:0] idx, input logic [4:0][31:0] val);
        exp_t e;
        e.sched = s;
        e.due   = 32'(due);
        e.idx   = idx;
        e.val   = val;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_done(input string tag, input int nw, input logic [1919:0] aw,
                              input logic av, input logic ab, input exp_t e);
        int bad = 0;
        cmp({tag, " done_cycle"}, 32'(cyc), e.due);
        cmp({tag, " w_valid_at_done"}, 32'(av), 32'd1);
        cmp({tag, " busy_at_done"}, 32'(ab), 32'd0);
        for (int j = 0; j < 5; j++) begin
            cmp($sformatf("%s w[%0d]", tag, e.idx[j]), wd(aw, int'(e.idx[j])), e.val[j]);
        end
        for (int i = 0; i < nw; i++) if (wd(aw, i) !== wd(e.sched, i)) bad++;
        cmp({tag, " schedule_words_wrong"}, 32'(bad), 32'd0);
    endtask

    // Monitor: pops the expected schedule whenever a DUT pulses done.
    always @(negedge clk) begin
        if (rst_n && d128) begin
            if (q128.size() == 0) cmp("aes128 unexpected_done", 32'd1, 32'd0);
            else check_done("aes128", 44, {512'b0, w128}, v128, b128, q128.pop_front());
        end
        if (rst_n && d192) begin
            if (q192.size() == 0) cmp("aes192 unexpected_done", 32'd1, 32'd0);
            else check_done("aes192", 52, {256'b0, w192}, v192, b192, q192.pop_front());
        end
        if (rst_n && d256) begin
            if (q256.size() == 0) cmp("aes256 unexpected_done", 32'd1, 32'd0);
            else check_done("aes256", 60, w256, v256, b256, q256.pop_front());
        end
    end

    task automatic go128(input logic [127:0] k);
        s128 = 1'b1; k128 = k; @(negedge clk); s128 = 1'b0;
    endtask
    task automatic go192(input logic [191:0] k);
        s192 = 1'b1; k192 = k; @(negedge clk); s192 = 1'b0;
    endtask
    task automatic go256(input logic [255:0] k);
        s256 = 1'b1; k256 = k; @(negedge clk); s256 = 1'b0;
    endtask
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    localparam logic [4:0][5:0]  I128 = {6'd43, 6'd42, 6'd41, 6'd40, 6'd4};
    localparam logic [4:0][31:0] V1 =
        {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8, 32'ha0fafe17};
    localparam logic [4:0][31:0] VZ =
        {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb, 32'h62636363};

    initial begin
        int n;
        for (int b = 0; b < 256; b++) ref_sb[b] = calc_sbox(8'(b));
        repeat (3) @(negedge clk);
        cmp("reset busy128", 32'(b128), 32'd0);
        cmp("reset done128", 32'(d128), 32'd0);
        cmp("reset w_valid128", 32'(v128), 32'd0);
        cmp("reset w128_nonzero", 32'(|w128), 32'd0);
        cmp("reset busy192", 32'(b192), 32'd0);
        cmp("reset w_valid192", 32'(v192), 32'd0);
        cmp("reset w192_nonzero", 32'(|w192), 32'd0);
        cmp("reset busy256", 32'(b256), 32'd0);
        cmp("reset w_valid256", 32'(v256), 32'd0);
        cmp("reset w256_nonzero", 32'(|w256), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128 FIPS key, then the zero key back-to-back in the cycle after done.
        n = cyc;
        q128.push_back(mk(model({128'b0, K1}, 4), n + 41, I128, V1));
        go128(K1);
        cmp("t1 busy@N+1", 32'(b128), 32'd1);
        cmp("t1 w_valid@N+1", 32'(v128), 32'd0);
        wait_cyc(n + 42);
        n = cyc;
        q128.push_back(mk(model(256'b0, 4), n + 41, I128, VZ));
        go128(128'b0);
        wait_cyc(n + 5);
        cmp("t6 w[4]@N+5", wd({512'b0, w128}, 4), 32'h62636363);
`ifdef AES_KEYEXP_CLEAR_EN
        cmp("t6 w[43]@N+5", wd({512'b0, w128}, 43), 32'h00000000);
`else
        cmp("t6 w[43]@N+5", wd({512'b0, w128}, 43), 32'hb6630ca6);
`endif
        wait_cyc(n + 42);

        // AES-192 and AES-256 FIPS keys.
        n = cyc;
        q192.push_back(mk(model({64'b0, K2}, 6), n + 47, {6'd51, 6'd50, 6'd49, 6'd48, 6'd6},
            {32'h01002202, 32'h8ecc7204, 32'h448c773c, 32'he98ba06f, 32'hfe0c91f7}));
        go192(K2);
        wait_cyc(n + 48);
        n = cyc;
        q256.push_back(mk(model(K3, 8), n + 53, {6'd59, 6'd58, 6'd57, 6'd56, 6'd8},
            {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1, 32'h9ba35411}));
        go256(K3);
        k256 = ~K3;
        wait_cyc(n + 54);

        // Start and key change while busy must be ignored.
        n = cyc;
        q128.push_back(mk(model({128'b0, K1}, 4), n + 41, I128, V1));
        go128(K1);
        cmp("t4 busy@N+1", 32'(b128), 32'd1);
        wait_cyc(n + 10);
        cmp("t4 busy@N+10", 32'(b128), 32'd1);
        go128(128'b0);
        wait_cyc(n + 40);
        cmp("t4 busy@N+40", 32'(b128), 32'd1);
        wait_cyc(n + 41);
        cmp("t4 busy@N+41", 32'(b128), 32'd0);
        wait_cyc(n + 42);

        // Asynchronous reset mid-expansion, then a clean restart.
        n = cyc;
        go128(128'b0);
        wait_cyc(n + 20);
        rst_n = 1'b0;
        #1;
        cmp("t5 busy_after_rst", 32'(b128), 32'd0);
        cmp("t5 w_valid_after_rst", 32'(v128), 32'd0);
        cmp("t5 w_nonzero_after_rst", 32'(|w128), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n = cyc;
        q128.push_back(mk(model({128'b0, K1}, 4), n + 41, I128, V1));
        go128(K1);
        wait_cyc(n + 42);

        for (int k = 0; k < 100 && (q128.size() + q192.size() + q256.size()) != 0; k++) begin
            @(negedge clk);
        end
        cmp("pending_done_count", 32'(q128.size() + q192.size() + q256.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
